// File: rtl/store_trace_fifo.sv
// Store trace FIFO: captures CPU stores {DataAdr, WriteData} in a first-word-fall-through queue.
// Optional pass/fail/timeout checker FSM is built only when STORE_TRACE_CHECK_EN is defined.
module store_trace_fifo #(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] DONE_ADDR    = 32'd100,
    parameter logic [31:0] DONE_DATA    = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR = 32'd96,
    parameter logic [15:0] TIMEOUT      = 16'd1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [31:0]              rd_addr,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [1:0]               status,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;

    assign full     = (count == FULL_COUNT);
    assign rd_valid = (count != '0);
    assign pop      = rd_en && rd_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the store.
    assign push     = MemWrite && (!full || pop);
    assign rd_addr  = addr_mem[rd_ptr];
    assign rd_data  = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            addr_mem[wr_ptr] <= DataAdr;
            data_mem[wr_ptr] <= WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (MemWrite && !push)
                overflow <= 1'b1;
        end
    end

`ifdef STORE_TRACE_CHECK_EN
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

    state_t      state;
    state_t      next_state;
    logic [15:0] cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_RUN;
            cycles <= '0;
        end else begin
            state <= next_state;
            if (state == ST_RUN)
                cycles <= cycles + 16'd1;
        end
    end

    // Decisions look at the raw store strobe, so dropped stores are still judged.
    always_comb begin
        next_state = state;
        if (state == ST_RUN) begin
            if (MemWrite && DataAdr == DONE_ADDR)
                next_state = (WriteData == DONE_DATA) ? ST_PASS : ST_FAIL;
            else if (MemWrite && DataAdr != SCRATCH_ADDR)
                next_state = ST_FAIL;
            else if (cycles == TIMEOUT_LAST)
                next_state = ST_TIMEOUT;
        end
    end

    assign status = state;
    assign done   = (state != ST_RUN);
`else
    logic unused_checker_cfg;

    assign unused_checker_cfg = ^{DONE_ADDR, DONE_DATA, SCRATCH_ADDR, TIMEOUT};
    assign status = 2'b00;
    assign done   = 1'b0;
`endif

endmodule

// File: tb/tb_store_trace_fifo.sv
// Directed scoreboard bench for store_trace_fifo (DEPTH=8, TIMEOUT=20).
// Status expectations depend on whether STORE_TRACE_CHECK_EN is defined.
module tb_store_trace_fifo;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  count;
    logic        overflow;
    logic [1:0]  status;
    logic        done;

    int compared   = 0;
    int mismatched = 0;
    logic [63:0] sb[$];
    logic        exp_overflow;

    store_trace_fifo #(
        .DEPTH(8),
        .DONE_ADDR(32'd100),
        .DONE_DATA(32'd7),
        .SCRATCH_ADDR(32'd96),
        .TIMEOUT(16'd20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .DataAdr(DataAdr),
        .WriteData(WriteData),
        .rd_en(rd_en),
        .rd_valid(rd_valid),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .count(count),
        .overflow(overflow),
        .status(status),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // The checker only exists when the macro is defined; otherwise status is tied to RUN.
    task automatic checkStatus(input string tag, input logic [1:0] exp_checker);
        logic [1:0] exp;
`ifdef STORE_TRACE_CHECK_EN
        exp = exp_checker;
`else
        exp = 2'b00;
`endif
        checkOutput({tag, "_status"}, 64'(status), 64'(exp));
        checkOutput({tag, "_done"}, 64'(done), 64'(exp != 2'b00));
    endtask

    task automatic doReset();
        reset     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = 32'd200;
        WriteData = 32'd55;
        rd_en     = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        exp_overflow = 1'b0;
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_valid", 64'(rd_valid), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
        checkStatus("rst", 2'b00);
        MemWrite = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] adr,
                                 input logic [31:0] wd, input logic re);
        logic pop;
        logic push;
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wd;
        rd_en     = re;
        pop  = re && (sb.size() > 0);
        push = we && ((sb.size() < 8) || pop);
        if (pop)
            checkOutput({tag, "_head"}, {rd_addr, rd_data}, sb[0]);
        if (we && !push)
            exp_overflow = 1'b1;
        @(posedge clk);
        #1;
        if (pop)
            void'(sb.pop_front());
        if (push)
            sb.push_back({adr, wd});
        MemWrite = 1'b0;
        rd_en    = 1'b0;
        checkOutput({tag, "_count"}, 64'(count), 64'(sb.size()));
        checkOutput({tag, "_valid"}, 64'(rd_valid), 64'(sb.size() != 0));
        checkOutput({tag, "_ovf"}, 64'(overflow), 64'(exp_overflow));
    endtask

    initial begin
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        rd_en     = 1'b0;
        exp_overflow = 1'b0;

        // Timeout after exactly 20 idle cycles.
        doReset();
        for (int i = 0; i < 19; i++)
            applyStimulus("idle", 1'b0, 32'd0, 32'd0, 1'b0);
        checkStatus("pre_timeout", 2'b00);
        applyStimulus("idle20", 1'b0, 32'd0, 32'd0, 1'b0);
        checkStatus("timeout", 2'b11);

        // Terminating store on the 20th edge wins over timeout.
        doReset();
        for (int i = 0; i < 19; i++)
            applyStimulus("idle", 1'b0, 32'd0, 32'd0, 1'b0);
        applyStimulus("pass20", 1'b1, 32'd100, 32'd7, 1'b0);
        checkStatus("pass20", 2'b01);

        // Scratch then passing store, then pop both in order.
        doReset();
        applyStimulus("scratch", 1'b1, 32'd96, 32'd3, 1'b0);
        checkStatus("scratch", 2'b00);
        applyStimulus("passst", 1'b1, 32'd100, 32'd7, 1'b0);
        checkStatus("pass", 2'b01);
        applyStimulus("pop1", 1'b0, 32'd0, 32'd0, 1'b1);
        applyStimulus("pop2", 1'b0, 32'd0, 32'd0, 1'b1);
        applyStimulus("pop_empty", 1'b0, 32'd0, 32'd0, 1'b1);
        applyStimulus("pushpop_empty", 1'b1, 32'd96, 32'h99, 1'b1);
        applyStimulus("pop3", 1'b0, 32'd0, 32'd0, 1'b1);

        // Wrong done data fails and stays failed.
        doReset();
        applyStimulus("baddata", 1'b1, 32'd100, 32'd5, 1'b0);
        checkStatus("baddata", 2'b10);
        applyStimulus("late_pass", 1'b1, 32'd100, 32'd7, 1'b0);
        checkStatus("sticky_fail", 2'b10);

        // Illegal address fails; the entry is still readable.
        doReset();
        applyStimulus("badaddr", 1'b1, 32'd200, 32'd1, 1'b0);
        checkStatus("badaddr", 2'b10);
        applyStimulus("badaddr_pop", 1'b0, 32'd0, 32'd0, 1'b1);

        // Nine stores into eight entries: ninth dropped, overflow sticky.
        doReset();
        for (int i = 0; i < 9; i++)
            applyStimulus("fill", 1'b1, 32'd96, 32'h10 + 32'(i), 1'b0);
        checkOutput("full_count", 64'(count), 64'd8);
        checkOutput("full_ovf", 64'(overflow), 64'd1);
        checkStatus("full", 2'b00);
        for (int i = 0; i < 8; i++)
            applyStimulus("drain", 1'b0, 32'd0, 32'd0, 1'b1);
        applyStimulus("drain_empty", 1'b0, 32'd0, 32'd0, 1'b1);

        // Store with pop on a full FIFO is accepted; pointers wrap.
        doReset();
        for (int i = 0; i < 8; i++)
            applyStimulus("fill2", 1'b1, 32'd96, 32'h20 + 32'(i), 1'b0);
        applyStimulus("full_pushpop", 1'b1, 32'd96, 32'h28, 1'b1);
        checkOutput("pushpop_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++)
            applyStimulus("drain2", 1'b0, 32'd0, 32'd0, 1'b1);

        // Asynchronous reset mid-operation flushes without a clock edge.
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus("pre_async", 1'b1, 32'd96, 32'(i + 1), 1'b0);
        applyStimulus("pre_async_pass", 1'b1, 32'd100, 32'd7, 1'b0);
        checkOutput("pre_async_count", 64'(count), 64'd5);
        checkStatus("pre_async", 2'b01);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_count", 64'(count), 64'd0);
        checkOutput("async_valid", 64'(rd_valid), 64'd0);
        checkStatus("async", 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        exp_overflow = 1'b0;
        applyStimulus("post_async", 1'b1, 32'd96, 32'h77, 1'b0);
        applyStimulus("post_async_pop", 1'b0, 32'd0, 32'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
